// File: rtl/regfile_scan_reader.sv
// Register-file scan reader: walks a read pointer over registers 0..NUM_REGS-1,
// advancing on a prescaled tick or a synchronised push-button press, and latches each value.
module regfile_scan_reader #(
    parameter int TICK_COUNT = 30000000,
    parameter int NUM_REGS   = 16,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic                  AutoScan,
    input  logic                  Step,
    input  logic [DATA_WIDTH-1:0] RegData,
    output logic [3:0]            ReadSelect,
    output logic [DATA_WIDTH-1:0] Value,
    output logic [3:0]            Index,
    output logic                  Valid,
    output logic                  Wrapped
);

    localparam int PRESC_W = (TICK_COUNT > 1) ? $clog2(TICK_COUNT) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_COUNT - 1);
    localparam logic [3:0] LAST_REG = 4'(NUM_REGS - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        SHOW    = 2'd3
    } state_t;

    state_t               state_r;
    logic [PRESC_W-1:0]   presc_r;
    logic                 step_sync1_r;
    logic                 step_sync2_r;
    logic                 step_hist_r;
    logic                 step_evt_s;
    logic                 tick_s;
    logic                 advance_s;

    // Press edge: released last cycle, pressed now (button is active-low).
    assign step_evt_s = step_hist_r & ~step_sync2_r;
    assign tick_s     = (presc_r == PRESC_LAST);
    assign advance_s  = AutoScan ? tick_s : step_evt_s;

    // Two-flop synchroniser plus history flop for the raw push-button.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            step_sync1_r <= 1'b1;
            step_sync2_r <= 1'b1;
            step_hist_r  <= 1'b1;
        end else begin
            step_sync1_r <= Step;
            step_sync2_r <= step_sync1_r;
            step_hist_r  <= step_sync2_r;
        end
    end

    // Scan sequencer: issue read, capture, then dwell until the next advance.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_r    <= IDLE;
            presc_r    <= '0;
            ReadSelect <= 4'd0;
            Value      <= '0;
            Index      <= 4'd0;
            Valid      <= 1'b0;
            Wrapped    <= 1'b0;
        end else begin
            Wrapped <= 1'b0;
            if (Start) begin
                ReadSelect <= 4'd0;
                Valid      <= 1'b0;
                presc_r    <= '0;
                state_r    <= ISSUE;
            end else begin
                case (state_r)
                    IDLE: begin
                        state_r <= IDLE;
                    end
                    ISSUE: begin
                        state_r <= CAPTURE;
                    end
                    CAPTURE: begin
                        Value   <= RegData;
                        Index   <= ReadSelect;
                        Valid   <= 1'b1;
                        presc_r <= '0;
                        state_r <= SHOW;
                    end
                    SHOW: begin
                        // Saturating count keeps a late AutoScan switch advancing promptly.
                        if (!tick_s) begin
                            presc_r <= presc_r + PRESC_W'(1);
                        end else begin
                            presc_r <= presc_r;
                        end
                        if (advance_s) begin
                            if (ReadSelect == LAST_REG) begin
                                ReadSelect <= 4'd0;
                                Wrapped    <= 1'b1;
                            end else begin
                                ReadSelect <= ReadSelect + 4'd1;
                            end
                            state_r <= ISSUE;
                        end else begin
                            state_r <= SHOW;
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_regfile_scan_reader.sv
// Self-checking bench for regfile_scan_reader with TICK_COUNT=4 and a behavioural register file.
module tb_regfile_scan_reader;

    localparam int TC     = 4;
    localparam int NR     = 16;
    localparam int DW     = 16;
    localparam int PERIOD = TC + 2;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic          auto_scan;
    logic          step;
    logic [DW-1:0] reg_data;
    logic [3:0]    read_select;
    logic [DW-1:0] value;
    logic [3:0]    index;
    logic          valid;
    logic          wrapped;

    logic [DW-1:0] regs [NR];
    int errors = 0;
    int checks = 0;

    assign reg_data = regs[read_select];

    always #5 clock = ~clock;

    regfile_scan_reader #(.TICK_COUNT(TC), .NUM_REGS(NR), .DATA_WIDTH(DW)) dut (
        .Clock(clock), .Reset(reset), .Start(start), .AutoScan(auto_scan), .Step(step),
        .RegData(reg_data), .ReadSelect(read_select), .Value(value), .Index(index),
        .Valid(valid), .Wrapped(wrapped)
    );

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'($urandom); auto_scan = 1'($urandom); step = 1'b1;
        cyc(2);
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", valid); end
        checks++; if (value !== '0) begin errors++; $display("FAIL reset_value: got %0d want 0", value); end
        checks++; if (index !== 4'd0) begin errors++; $display("FAIL reset_index: got %0d want 0", index); end
        checks++; if (read_select !== 4'd0) begin errors++; $display("FAIL reset_rsel: got %0d want 0", read_select); end
        checks++; if (wrapped !== 1'b0) begin errors++; $display("FAIL reset_wrapped: got %0b want 0", wrapped); end
        reset = 1'b0; start = 1'b0; auto_scan = 1'b0;
        step = 1'b0; cyc(6); step = 1'b1; cyc(4);
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL idle_step_valid: got %0b want 0", valid); end
        checks++; if (read_select !== 4'd0) begin errors++; $display("FAIL idle_step_rsel: got %0d want 0", read_select); end
    endtask

    // Auto scan over the whole file and one wrap; t counts edges after the Start edge.
    task automatic test_auto_scan;
        for (int i = 0; i < NR; i++) regs[i] = DW'(i * 3);
        auto_scan = 1'b1; start = 1'b1;
        cyc(1);
        start = 1'b0;
        for (int t = 0; t <= 100; t++) begin
            int rs_exp  = (t / PERIOD) % NR;
            int idx_exp = ((t - 2) / PERIOD) % NR;
            logic wr_exp = (t > 0) && (t % (PERIOD * NR) == 0);
            checks++; if (read_select !== 4'(rs_exp)) begin errors++; $display("FAIL auto_rsel t=%0d: got %0d want %0d", t, read_select, rs_exp); end
            checks++; if (wrapped !== wr_exp) begin errors++; $display("FAIL auto_wrapped t=%0d: got %0b want %0b", t, wrapped, wr_exp); end
            checks++; if (valid !== (t >= 2)) begin errors++; $display("FAIL auto_valid t=%0d: got %0b want %0b", t, valid, (t >= 2)); end
            if (t >= 2) begin
                checks++; if (index !== 4'(idx_exp)) begin errors++; $display("FAIL auto_index t=%0d: got %0d want %0d", t, index, idx_exp); end
                checks++; if (value !== regs[idx_exp]) begin errors++; $display("FAIL auto_value t=%0d: got %0d want %0d", t, value, regs[idx_exp]); end
            end
            if (t < 100) cyc(1);
        end
    endtask

    task automatic test_manual_step;
        int expi = 0;
        auto_scan = 1'b0; start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(2);
        checks++; if (index !== 4'd0 || valid !== 1'b1) begin errors++; $display("FAIL step_first: got idx=%0d v=%0b want 0/1", index, valid); end
        for (int p = 1; p <= 3; p++) begin
            step = 1'b0;
            for (int j = 1; j <= 10; j++) begin
                cyc(1);
                if (j == 2) begin
                    checks++; if (read_select !== 4'(expi)) begin errors++; $display("FAIL step_rsel_early p=%0d: got %0d want %0d", p, read_select, expi); end
                end
                if (j == 3) begin
                    checks++; if (read_select !== 4'(expi + 1)) begin errors++; $display("FAIL step_rsel p=%0d: got %0d want %0d", p, read_select, expi + 1); end
                end
                if (j == 4) begin
                    checks++; if (index !== 4'(expi)) begin errors++; $display("FAIL step_idx_early p=%0d: got %0d want %0d", p, index, expi); end
                end
                if (j == 5) begin
                    step = 1'b1;
                    checks++; if (index !== 4'(expi + 1)) begin errors++; $display("FAIL step_idx p=%0d: got %0d want %0d", p, index, expi + 1); end
                end
            end
            expi++;
            checks++; if (index !== 4'(expi) || value !== regs[expi]) begin errors++; $display("FAIL step_hold p=%0d: got %0d/%0d want %0d/%0d", p, index, value, expi, regs[expi]); end
        end
        step = 1'b0;
        for (int j = 1; j <= 40; j++) begin
            cyc(1);
            if (j == 5 || j == 40) begin
                checks++; if (index !== 4'(expi + 1)) begin errors++; $display("FAIL long_press j=%0d: got %0d want %0d", j, index, expi + 1); end
            end
        end
        step = 1'b1;
        cyc(6);
        checks++; if (index !== 4'(expi + 1) || value !== regs[expi + 1]) begin errors++; $display("FAIL long_release: got %0d/%0d want %0d/%0d", index, value, expi + 1, regs[expi + 1]); end
    endtask

    task automatic test_restart;
        auto_scan = 1'b1; start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(45);
        checks++; if (index !== 4'd7 || valid !== 1'b1) begin errors++; $display("FAIL restart_pre: got idx=%0d v=%0b want 7/1", index, valid); end
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        checks++; if (valid !== 1'b0 || read_select !== 4'd0) begin errors++; $display("FAIL restart_clear: got v=%0b rs=%0d want 0/0", valid, read_select); end
        checks++; if (wrapped !== 1'b0) begin errors++; $display("FAIL restart_wrap0: got %0b want 0", wrapped); end
        cyc(1);
        checks++; if (wrapped !== 1'b0 || valid !== 1'b0) begin errors++; $display("FAIL restart_wrap1: got w=%0b v=%0b want 0/0", wrapped, valid); end
        cyc(1);
        checks++; if (index !== 4'd0 || valid !== 1'b1 || value !== regs[0]) begin errors++; $display("FAIL restart_cap: got %0d/%0b/%0d want 0/1/%0d", index, valid, value, regs[0]); end
    endtask

    task automatic test_reset_capture;
        auto_scan = 1'b1; start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(31);
        checks++; if (index !== 4'd4 || value !== regs[4]) begin errors++; $display("FAIL rstcap_pre: got %0d/%0d want 4/%0d", index, value, regs[4]); end
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        checks++; if (value !== '0 || index !== 4'd0) begin errors++; $display("FAIL rstcap_data: got %0d/%0d want 0/0", value, index); end
        checks++; if (valid !== 1'b0 || read_select !== 4'd0 || wrapped !== 1'b0) begin errors++; $display("FAIL rstcap_ctl: got v=%0b rs=%0d w=%0b want 0/0/0", valid, read_select, wrapped); end
        auto_scan = 1'b0;
        step = 1'b0; cyc(6); step = 1'b1; cyc(4);
        checks++; if (valid !== 1'b0 || read_select !== 4'd0) begin errors++; $display("FAIL rstcap_step: got v=%0b rs=%0d want 0/0", valid, read_select); end
        auto_scan = 1'b1;
        cyc(10);
        checks++; if (valid !== 1'b0 || read_select !== 4'd0) begin errors++; $display("FAIL rstcap_idle: got v=%0b rs=%0d want 0/0", valid, read_select); end
    endtask

    task automatic test_mode_change;
        auto_scan = 1'b0; start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(12);
        checks++; if (read_select !== 4'd0 || index !== 4'd0) begin errors++; $display("FAIL mode_pre: got rs=%0d idx=%0d want 0/0", read_select, index); end
        auto_scan = 1'b1;
        cyc(1);
        checks++; if (read_select !== 4'd1) begin errors++; $display("FAIL mode_adv: got %0d want 1", read_select); end
        cyc(1);
        checks++; if (index !== 4'd0) begin errors++; $display("FAIL mode_hold: got %0d want 0", index); end
        cyc(1);
        checks++; if (index !== 4'd1 || value !== regs[1]) begin errors++; $display("FAIL mode_cap: got %0d/%0d want 1/%0d", index, value, regs[1]); end
    endtask

    // Random contents, random Start hold length, random (ignored) Step noise, restart from any state.
    task automatic test_random_auto;
        for (int it = 0; it < 4; it++) begin
            int hold = $urandom_range(1, 3);
            int n    = $urandom_range(30, 110);
            for (int i = 0; i < NR; i++) regs[i] = DW'($urandom);
            auto_scan = 1'b1;
            for (int h = 0; h < hold; h++) begin
                start = 1'b1;
                cyc(1);
                checks++; if (valid !== 1'b0 || read_select !== 4'd0 || wrapped !== 1'b0) begin errors++; $display("FAIL rand_start it=%0d: got v=%0b rs=%0d w=%0b want 0/0/0", it, valid, read_select, wrapped); end
            end
            start = 1'b0;
            for (int t = 0; t <= n; t++) begin
                int rs_exp  = (t / PERIOD) % NR;
                int idx_exp = ((t - 2) / PERIOD) % NR;
                logic wr_exp = (t > 0) && (t % (PERIOD * NR) == 0);
                checks++; if (read_select !== 4'(rs_exp)) begin errors++; $display("FAIL rand_rsel it=%0d t=%0d: got %0d want %0d", it, t, read_select, rs_exp); end
                checks++; if (wrapped !== wr_exp) begin errors++; $display("FAIL rand_wrapped it=%0d t=%0d: got %0b want %0b", it, t, wrapped, wr_exp); end
                if (t >= 2) begin
                    checks++; if (valid !== 1'b1 || index !== 4'(idx_exp) || value !== regs[idx_exp]) begin errors++; $display("FAIL rand_cap it=%0d t=%0d: got %0b/%0d/%0d want 1/%0d/%0d", it, t, valid, index, value, idx_exp, regs[idx_exp]); end
                end
                step = 1'($urandom);
                if (t < n) cyc(1);
            end
            step = 1'b1;
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; auto_scan = 1'b0; step = 1'b1;
        for (int i = 0; i < NR; i++) regs[i] = DW'(i * 3);
        cyc(1);
        test_reset();
        test_auto_scan();
        test_manual_step();
        test_restart();
        test_reset_capture();
        test_mode_change();
        test_random_auto();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
